// File: rtl/core_pwr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : core_pwr_ctrl
//  Description : Multi-core clock-gate / reset-release sequencer. For every
//                core the asynchronous enable request is synchronised and a
//                small FSM orders the clock-gate enable and the core reset:
//                clock on before reset release, reset asserted before the
//                clock is gated. A soft-restart pulse re-runs the reset
//                release sequence with the clock kept on.
//  Revision    : 1.0 - initial multi-core release
// ============================================================================
module core_pwr_ctrl #(
    parameter int NUM_CORES  = 4,
    parameter int RST_DELAY  = 7,   // clk_en rise -> core_reset_n rise (>=1)
    parameter int GATE_DELAY = 4,   // core_reset_n fall -> clk_en fall (>=1)
    parameter int CNT_W      = 4    // must hold max(RST_DELAY, GATE_DELAY)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NUM_CORES-1:0] core_en_i,
    input  logic [NUM_CORES-1:0] restart_i,
    output logic [NUM_CORES-1:0] clk_en_o,
    output logic [NUM_CORES-1:0] core_reset_n_o,
    output logic [NUM_CORES-1:0] running_o,
    output logic [NUM_CORES-1:0] busy_o
);

    // Per-core sequencing states
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_CLK_ON  = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RESTART = 3'd4
    } state_t;

    // Terminal counts: the counter starts at 0 on state entry, so the
    // terminal compare fires after exactly RST_DELAY / GATE_DELAY cycles.
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_DELAY - 1);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Output bundle order: {clk_en, reset_n, running, busy}
    function automatic logic [3:0] decode(input state_t s);
        logic [3:0] o;
        o = 4'b0000;
        case (s)
            ST_OFF:     o = 4'b0000;
            ST_CLK_ON:  o = 4'b1001;
            ST_RUN:     o = 4'b1110;
            ST_DRAIN:   o = 4'b1001;
            ST_RESTART: o = 4'b1001;
            default:    o = 4'b0000;
        endcase
        return o;
    endfunction

    logic [NUM_CORES-1:0] en_meta;
    logic [NUM_CORES-1:0] en_sync;

    // Two-flop synchroniser for the asynchronous per-core enable requests
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            en_meta <= '0;
            en_sync <= '0;
        end else begin
            en_meta <= core_en_i;
            en_sync <= en_meta;
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic [3:0]       outs;
        logic             en_s;

        assign en_s = en_sync[gi];

        // Sequencing FSM with counter; outputs are registered from the
        // next state so they change on the same edge as the state.
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                state <= ST_OFF;
                cnt   <= '0;
                outs  <= 4'b0000;
            end else begin
                case (state)
                    ST_OFF: begin
                        // restart_i is meaningless without a clock
                        if (en_s) begin
                            state <= ST_CLK_ON;
                            cnt   <= '0;
                            outs  <= decode(ST_CLK_ON);
                        end
                    end

                    ST_CLK_ON, ST_RESTART: begin
                        // Withdrawal of enable always wins over release
                        if (!en_s) begin
                            state <= ST_DRAIN;
                            cnt   <= '0;
                            outs  <= decode(ST_DRAIN);
                        end else if (cnt == RST_LAST) begin
                            state <= ST_RUN;
                            cnt   <= '0;
                            outs  <= decode(ST_RUN);
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    ST_RUN: begin
                        // Power-down has priority over a concurrent restart
                        if (!en_s) begin
                            state <= ST_DRAIN;
                            cnt   <= '0;
                            outs  <= decode(ST_DRAIN);
                        end else if (restart_i[gi]) begin
                            state <= ST_RESTART;
                            cnt   <= '0;
                            outs  <= decode(ST_RESTART);
                        end
                    end

                    ST_DRAIN: begin
                        // Drain runs to completion regardless of en_s
                        if (cnt == GATE_LAST) begin
                            state <= ST_OFF;
                            cnt   <= '0;
                            outs  <= decode(ST_OFF);
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        state <= ST_OFF;
                        cnt   <= '0;
                        outs  <= decode(ST_OFF);
                    end
                endcase
            end
        end

        assign clk_en_o[gi]       = outs[3];
        assign core_reset_n_o[gi] = outs[2];
        assign running_o[gi]      = outs[1];
        assign busy_o[gi]         = outs[0];
    end

endmodule
`default_nettype wire

// File: tb/tb_core_pwr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_pwr_ctrl
//  Description : Self-checking bench for core_pwr_ctrl. A timeline model
//                (phase plus absolute end time per core) predicts every
//                output on every cycle; directed steps pin the key timings
//                to absolute cycle numbers, then a random phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_pwr_ctrl;

    localparam int NC    = 2;
    localparam int RDLY  = 7;
    localparam int GDLY  = 4;

    localparam int P_OFF     = 0;
    localparam int P_CLK_ON  = 1;
    localparam int P_RUN     = 2;
    localparam int P_DRAIN   = 3;
    localparam int P_RESTART = 4;

    logic          clk;
    logic          reset_n;
    logic [NC-1:0] core_en;
    logic [NC-1:0] restart;
    logic [NC-1:0] clk_en_o;
    logic [NC-1:0] core_reset_n_o;
    logic [NC-1:0] running_o;
    logic [NC-1:0] busy_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: phase, the cycle at which the timed phase ends, and the
    // enable history (en_s is the request as seen two edges earlier).
    int ph    [NC];
    int end_t [NC];
    bit h1    [NC];
    bit h2    [NC];

    core_pwr_ctrl #(
        .NUM_CORES (NC),
        .RST_DELAY (RDLY),
        .GATE_DELAY(GDLY),
        .CNT_W     (4)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .core_en_i     (core_en),
        .restart_i     (restart),
        .clk_en_o      (clk_en_o),
        .core_reset_n_o(core_reset_n_o),
        .running_o     (running_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock edge: update model from the inputs present at the
    // edge, then compare every output after the edge has settled.
    task automatic step();
        logic [NC-1:0] e_clk, e_rst, e_run, e_busy;
        @(posedge clk);
        cyc++;
        for (int c = 0; c < NC; c++) begin
            if (!reset_n) begin
                ph[c] = P_OFF;
                h1[c] = 1'b0;
                h2[c] = 1'b0;
            end else begin
                bit es;
                es = h2[c];
                case (ph[c])
                    P_OFF: if (es) begin ph[c] = P_CLK_ON; end_t[c] = cyc + RDLY; end
                    P_CLK_ON, P_RESTART: begin
                        if (!es) begin ph[c] = P_DRAIN; end_t[c] = cyc + GDLY; end
                        else if (cyc == end_t[c]) ph[c] = P_RUN;
                    end
                    P_RUN: begin
                        if (!es) begin ph[c] = P_DRAIN; end_t[c] = cyc + GDLY; end
                        else if (restart[c]) begin ph[c] = P_RESTART; end_t[c] = cyc + RDLY; end
                    end
                    P_DRAIN: if (cyc == end_t[c]) ph[c] = P_OFF;
                    default: ph[c] = P_OFF;
                endcase
                h2[c] = h1[c];
                h1[c] = core_en[c];
            end
        end
        #1;
        for (int c = 0; c < NC; c++) begin
            e_clk[c]  = (ph[c] != P_OFF);
            e_rst[c]  = (ph[c] == P_RUN);
            e_run[c]  = (ph[c] == P_RUN);
            e_busy[c] = (ph[c] == P_CLK_ON) || (ph[c] == P_DRAIN) || (ph[c] == P_RESTART);
        end
        chk("model_clk_en", 32'(clk_en_o), 32'(e_clk));
        chk("model_reset_n", 32'(core_reset_n_o), 32'(e_rst));
        chk("model_running", 32'(running_o), 32'(e_run));
        chk("model_busy", 32'(busy_o), 32'(e_busy));
        chk("invariant", 32'(core_reset_n_o & ~clk_en_o), 32'd0);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        reset_n = 1'b0;
        core_en = '0;
        restart = '0;
        for (int c = 0; c < NC; c++) begin
            ph[c] = P_OFF; end_t[c] = 0; h1[c] = 1'b0; h2[c] = 1'b0;
        end

        // Reset state
        run_to(3);
        chk("rst_clk_en", 32'(clk_en_o), 32'd0);
        chk("rst_reset_n", 32'(core_reset_n_o), 32'd0);
        chk("rst_running", 32'(running_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        reset_n = 1'b1;

        // Power-up of core 0
        run_to(10); core_en[0] = 1'b1;
        run_to(12); chk("up_clk_early", 32'(clk_en_o[0]), 32'd0);
        run_to(13); chk("up_clk_on", 32'(clk_en_o[0]), 32'd1);
                    chk("up_rst_held", 32'(core_reset_n_o[0]), 32'd0);
        run_to(19); chk("up_rst_early", 32'(core_reset_n_o[0]), 32'd0);
        run_to(20); chk("up_rst_rel", 32'(core_reset_n_o[0]), 32'd1);
                    chk("up_running", 32'(running_o[0]), 32'd1);
                    chk("up_core1_idle", 32'({clk_en_o[1], core_reset_n_o[1]}), 32'd0);

        // Soft restart, with a second pulse ignored
        run_to(30); restart[0] = 1'b1;
        step();     restart[0] = 1'b0;
        chk("rs_rst_low", 32'(core_reset_n_o[0]), 32'd0);
        chk("rs_clk_held", 32'(clk_en_o[0]), 32'd1);
        run_to(33); restart[0] = 1'b1;
        step();     restart[0] = 1'b0;
        run_to(37); chk("rs_rst_early", 32'(core_reset_n_o[0]), 32'd0);
        run_to(38); chk("rs_rst_rel", 32'(core_reset_n_o[0]), 32'd1);

        // Orderly power-down
        run_to(50); core_en[0] = 1'b0;
        run_to(52); chk("dn_still_run", 32'(core_reset_n_o[0]), 32'd1);
        run_to(53); chk("dn_rst_low", 32'(core_reset_n_o[0]), 32'd0);
                    chk("dn_busy_first", 32'(busy_o[0]), 32'd1);
        run_to(56); chk("dn_busy_last", 32'(busy_o[0]), 32'd1);
                    chk("dn_clk_still", 32'(clk_en_o[0]), 32'd1);
        run_to(57); chk("dn_clk_gated", 32'(clk_en_o[0]), 32'd0);
                    chk("dn_busy_done", 32'(busy_o[0]), 32'd0);

        // Restart coinciding with en_s falling: drain wins
        run_to(60); core_en[0] = 1'b1;
        run_to(70); chk("c_running", 32'(running_o[0]), 32'd1);
        run_to(80); core_en[0] = 1'b0;
        run_to(82); restart[0] = 1'b1;
        step();     restart[0] = 1'b0;
        chk("c_drain_busy", 32'(busy_o[0]), 32'd1);
        chk("c_drain_rst", 32'(core_reset_n_o[0]), 32'd0);
        run_to(86); chk("c_clk_still", 32'(clk_en_o[0]), 32'd1);
        run_to(87); chk("c_clk_gated", 32'(clk_en_o[0]), 32'd0);
                    chk("c_no_run", 32'(running_o[0]), 32'd0);

        // Enable glitch during CLK_ON (core 0) with core 1 skewed
        run_to(100); core_en[0] = 1'b1;
        run_to(102); core_en[1] = 1'b1;
        run_to(104); core_en[0] = 1'b0;
        run_to(105); core_en[0] = 1'b1;
        run_to(106); chk("g_clk_on", 32'(busy_o[0]), 32'd1);
        run_to(110); chk("g_drain_clk", 32'(clk_en_o[0]), 32'd1);
        run_to(111); chk("g_off_cycle", 32'(clk_en_o[0]), 32'd0);
        run_to(112); chk("g_reclk", 32'(clk_en_o[0]), 32'd1);
                     chk("g_core1_run", 32'(core_reset_n_o[1]), 32'd1);
        run_to(118); chk("g_rst_early", 32'(core_reset_n_o[0]), 32'd0);
        run_to(119); chk("g_rst_rel", 32'(core_reset_n_o[0]), 32'd1);

        // Reset with core 0 in RUN and core 1 in DRAIN
        run_to(125); core_en[1] = 1'b0;
        run_to(129); chk("r_core1_drain", 32'({busy_o[1], core_reset_n_o[1]}), 32'd2);
                     reset_n = 1'b0;
        step();      reset_n = 1'b1;
        chk("r_all_clk", 32'(clk_en_o), 32'd0);
        chk("r_all_rst", 32'(core_reset_n_o), 32'd0);
        chk("r_all_busy", 32'(busy_o | running_o), 32'd0);

        // Random phase
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 11) == 0) core_en[c] = ~core_en[c];
                restart[c] = ($urandom_range(0, 5) == 0);
            end
            reset_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_pwr_ctrl.md
Name: core_pwr_ctrl

Overview:
- Multi-core successor of the single-core clock-gate/reset-release controller, sitting between tile control registers and N processor cores.
- Per core: synchronises the enable request and sequences the clock-gate enable and the core reset.
- On enable: clock on first, reset released RST_DELAY cycles later. On disable: reset asserted first, clock gated GATE_DELAY cycles later.
- Adds a per-core soft-restart request; the predecessor has no orderly power-down or restart.

Parameters:
- NUM_CORES, 4, number of independently controlled cores.
- RST_DELAY, 7, cycles between clk_en_o rising and core_reset_n_o rising (>=1).
- GATE_DELAY, 4, cycles between core_reset_n_o falling and clk_en_o falling (>=1).
- CNT_W, 4, counter width; must hold max(RST_DELAY, GATE_DELAY).

Ports:
- clk_i  in  1  block clock; all logic on rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- core_en_i  in  NUM_CORES  per-core enable request, asynchronous to clk_i.
- restart_i  in  NUM_CORES  per-core soft-restart pulse, synchronous to clk_i.
- clk_en_o  out  NUM_CORES  enable to the external per-core clock gate.
- core_reset_n_o  out  NUM_CORES  active-low core reset, registered.
- running_o  out  NUM_CORES  1 while core is in RUN.
- busy_o  out  NUM_CORES  1 in CLK_ON, DRAIN or RESTART.

Behaviour:
- Reset: synchronous; reset_n_i low at a rising edge clears all state.
  - All cores go to OFF.
  - clk_en_o=0, core_reset_n_o=0, running_o=0, busy_o=0.
  - Synchroniser flops and counters are cleared.
  - Asserting reset mid-sequence forces OFF on the next edge, with no drain.
- Synchroniser: core_en_i passes through 2 flops per bit to give en_s. en_s lags core_en_i by 2 cycles.
- Cores are independent: one FSM and one CNT_W counter per core. All outputs are registered and decoded from state.
- FSM states and outputs (clk_en, reset_n):
  - OFF (0,0)
  - CLK_ON (1,0)
  - RUN (1,1)
  - DRAIN (1,0)
  - RESTART (1,0)
- OFF:
  - en_s=1 -> CLK_ON, cnt=0.
  - restart_i is ignored.
- CLK_ON:
  - cnt increments each cycle.
  - cnt==RST_DELAY-1 and en_s=1 -> RUN.
  - en_s=0 at any point -> DRAIN, cnt=0.
  - Net effect: clk_en_o rises exactly RST_DELAY cycles before core_reset_n_o.
- RUN:
  - en_s=0 -> DRAIN, cnt=0.
  - Otherwise restart_i=1 -> RESTART, cnt=0.
  - If both occur in the same cycle, DRAIN wins.
- DRAIN:
  - cnt increments each cycle.
  - cnt==GATE_DELAY-1 -> OFF.
  - Not abortable: en_s rising during DRAIN has no effect until OFF.
  - If en_s is still 1 in OFF, CLK_ON follows on the next cycle.
- RESTART:
  - Counts exactly like CLK_ON; at cnt==RST_DELAY-1 -> RUN.
  - en_s=0 -> DRAIN, cnt=0.
  - Further restart_i pulses are ignored.
- Counter is reset to 0 on every state entry. It never wraps: the terminal compare always fires first.
- Minimum end-to-end timings:
  - OFF->RUN: 2 (sync) + 1 + RST_DELAY cycles after core_en_i rises.
  - RUN->OFF: 2 + 1 + GATE_DELAY cycles after core_en_i falls.
- Invariant: core_reset_n_o=1 implies clk_en_o=1 on every cycle, for every core.

Test Plan:
- NUM_CORES=2, RST_DELAY=7, GATE_DELAY=4; core_en_i[0] 0->1 at cycle 10 -> clk_en_o[0]=1 at cycle 13, core_reset_n_o[0]=1 and running_o[0]=1 at cycle 20. Core 1 stays (0,0) throughout.
- Core 0 in RUN; core_en_i[0] 1->0 at cycle 50 -> core_reset_n_o[0]=0 at 53, clk_en_o[0]=0 at 57, busy_o[0]=1 for cycles 53-56.
- Core 0 in RUN; 1-cycle restart_i[0] at cycle 30 -> reset_n low at 31 with clk_en held 1, reset_n high at 38. A second restart pulse at 33 has no effect.
- Core 0 in RUN; restart_i[0] asserted in the same cycle en_s falls -> DRAIN taken: clock gated 4 cycles after reset assertion, no RUN re-entry.
- core_en_i toggled 1->0->1 so en_s drops for 1 cycle during CLK_ON (cnt=3) -> full DRAIN (4 cycles), one OFF cycle, then a fresh CLK_ON with a full 7-cycle delay. Both cores are driven concurrently with skewed timing and show no cross-coupling.
- reset_n_i pulled low for 1 cycle while core 0 is in RUN and core 1 is in DRAIN -> all outputs 0 on the next edge, both FSMs in OFF. Random-stimulus check of the invariant reset_n_o=1 implies clk_en_o=1.
